servant_tick_master: RTL and testbench



---
 rtl/servant_tick_master_pkg.sv | 15 +
 rtl/servant_tick_master.sv | 179 +++++++++++++++++
 tb/tb_servant_tick_master.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/servant_tick_master_pkg.sv
// rtl/servant_tick_master_pkg.sv - shared FSM state encoding and constants for the tick master
package servant_tick_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Cycles spent in HOLD so the responder's registered, now-stale irq is ignored.
  localparam int HOLD_CYCLES = 2;

endpackage

// File: rtl/servant_tick_master.sv
// rtl/servant_tick_master.sv - timer reschedule master (read t, write t+period); optional bus timeout via SERVANT_TICK_TIMEOUT_EN
module servant_tick_master
  import servant_tick_master_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_period,
  input  logic             i_irq,
  output logic             o_wb_cyc,
  output logic             o_wb_we,
  output logic [31:0]      o_wb_dat,
  input  logic [31:0]      i_wb_dat,
  input  logic             i_wb_ack,
  output logic             o_tick,
  output logic [15:0]      o_tick_cnt,
  output logic             o_err
);

  localparam logic [1:0] HOLD_LAST = 2'(HOLD_CYCLES - 1);

  state_t      state, state_d;
  logic        armed, armed_d;
  logic [1:0]  hold_cnt, hold_d;
  logic        cyc, cyc_d;
  logic        we, we_d;
  logic [31:0] dat, dat_d;
  logic        tick, tick_d;
  logic [15:0] tick_cnt, cnt_d;

  logic [WIDTH-1:0] per_eff;
  logic [WIDTH-1:0] sum;

`ifdef SERVANT_TICK_TIMEOUT_EN
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);
  logic       err, err_d;
  logic [3:0] wait_cnt, wait_d;
`endif

  // New compare value: read time plus period (0 means 1), wrapping at WIDTH bits.
  always_comb begin
    per_eff = (i_period == '0) ? WIDTH'(1) : i_period;
    sum     = i_wb_dat[WIDTH-1:0] + per_eff;
  end

  // All outputs are flops, so nothing reaches o_wb_cyc/o_wb_we combinationally from the ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      armed    <= 1'b0;
      hold_cnt <= 2'd0;
      cyc      <= 1'b0;
      we       <= 1'b0;
      dat      <= 32'd0;
      tick     <= 1'b0;
      tick_cnt <= 16'd0;
`ifdef SERVANT_TICK_TIMEOUT_EN
      err      <= 1'b0;
      wait_cnt <= 4'd0;
`endif
    end else begin
      state    <= state_d;
      armed    <= armed_d;
      hold_cnt <= hold_d;
      cyc      <= cyc_d;
      we       <= we_d;
      dat      <= dat_d;
      tick     <= tick_d;
      tick_cnt <= cnt_d;
`ifdef SERVANT_TICK_TIMEOUT_EN
      err      <= err_d;
      wait_cnt <= wait_d;
`endif
    end
  end

  // Next state and next register values; WR opens with one cyc-low cycle to separate it from RD.
  always_comb begin
    state_d = state;
    armed_d = armed;
    hold_d  = hold_cnt;
    cyc_d   = cyc;
    we_d    = we;
    dat_d   = dat;
    tick_d  = 1'b0;
    cnt_d   = tick_cnt;
`ifdef SERVANT_TICK_TIMEOUT_EN
    err_d   = err;
    wait_d  = wait_cnt;
`endif
    case (state)
      S_IDLE: begin
        hold_d = 2'd0;
        if (!i_en) begin
          armed_d = 1'b0;
        end else if (!armed || i_irq) begin
          state_d = S_RD;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
`ifdef SERVANT_TICK_TIMEOUT_EN
          wait_d  = 4'd0;
`endif
        end
      end
      S_RD: begin
        if (i_wb_ack) begin
          cyc_d   = 1'b0;
          dat_d   = 32'(sum);
          state_d = S_WR;
`ifdef SERVANT_TICK_TIMEOUT_EN
          wait_d  = 4'd0;
        end else if (wait_cnt == TO_LAST) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          wait_d  = wait_cnt + 4'd1;
`endif
        end
      end
      S_WR: begin
        if (!cyc) begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
        end else if (i_wb_ack) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          tick_d  = 1'b1;
          cnt_d   = tick_cnt + 16'd1;
          armed_d = 1'b1;
          hold_d  = 2'd0;
          state_d = S_HOLD;
`ifdef SERVANT_TICK_TIMEOUT_EN
        end else if (wait_cnt == TO_LAST) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          wait_d  = wait_cnt + 4'd1;
`endif
        end
      end
      S_HOLD: begin
        if (!i_en) begin
          armed_d = 1'b0;
          state_d = S_IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_cnt + 2'd1;
        end
      end
`ifdef SERVANT_TICK_TIMEOUT_EN
      S_ERR: begin
        state_d = S_ERR;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_wb_cyc   = cyc;
  assign o_wb_we    = we;
  assign o_wb_dat   = dat;
  assign o_tick     = tick;
  assign o_tick_cnt = tick_cnt;
`ifdef SERVANT_TICK_TIMEOUT_EN
  assign o_err      = err;
`else
  assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_servant_tick_master.sv
// tb/tb_servant_tick_master.sv - scoreboard bench for servant_tick_master (honours SERVANT_TICK_TIMEOUT_EN)
module tb_servant_tick_master;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] period;
  logic        irq;
  logic        wb_cyc;
  logic        wb_we;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack;
  logic        tick;
  logic [15:0] tick_cnt;
  logic        err;

  logic [31:0] rd_val;
  logic        noack;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] dat;
  } xfer_t;

  xfer_t       exp_xfer[$];
  logic [15:0] exp_tick[$];

  servant_tick_master #(.WIDTH(32), .TIMEOUT(15)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_period   (period),
    .i_irq      (irq),
    .o_wb_cyc   (wb_cyc),
    .o_wb_we    (wb_we),
    .o_wb_dat   (wb_dat_o),
    .i_wb_dat   (wb_dat_i),
    .i_wb_ack   (wb_ack),
    .o_tick     (tick),
    .o_tick_cnt (tick_cnt),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait timer responder: acks on cyc & !ack, read data is the bench's timer value.
  always @(posedge clk) begin
    if (rst) wb_ack <= 1'b0;
    else     wb_ack <= wb_cyc & ~wb_ack & ~noack;
  end
  assign wb_dat_i = rd_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_resched(input logic [31:0] wdat, input logic [15:0] cnt);
    exp_xfer.push_back('{we: 1'b0, dat: 32'd0});
    exp_xfer.push_back('{we: 1'b1, dat: wdat});
    exp_tick.push_back(cnt);
  endtask

  task automatic wait_tick(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (tick) seen = 1'b1;
    end
    chk({name, "_tick_seen"}, {31'd0, seen}, 32'd1);
  endtask

  // Monitor: every completed bus transfer and every tick is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_cyc && wb_ack) begin
        if (exp_xfer.size() == 0) begin
          chk("unexpected_xfer", {31'd0, wb_we}, 32'hFFFF_FFFF);
        end else begin
          xfer_t e;
          e = exp_xfer.pop_front();
          chk("xfer_we", {31'd0, wb_we}, {31'd0, e.we});
          if (e.we) chk("xfer_wdat", wb_dat_o, e.dat);
        end
      end
      if (tick) begin
        if (exp_tick.size() == 0) begin
          chk("unexpected_tick", {16'd0, tick_cnt}, 32'hFFFF_FFFF);
        end else begin
          logic [15:0] c;
          c = exp_tick.pop_front();
          chk("tick_cnt", {16'd0, tick_cnt}, {16'd0, c});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; irq = 1'b0; period = 32'd0; rd_val = 32'd0; noack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("rst_we",  {31'd0, wb_we}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_cnt", {16'd0, tick_cnt}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // Unarmed start: read 7, period 100 -> write 107, tick exactly 5 cycles in.
    @(negedge clk);
    push_resched(32'd107, 16'd1);
    rst = 1'b0; en = 1'b1; rd_val = 32'd7; period = 32'd100;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("t1_tick_early", {31'd0, tick}, 32'd0);
    @(posedge clk);
    #1;
    chk("t1_tick_at5", {31'd0, tick}, 32'd1);
    chk("t1_cnt", {16'd0, tick_cnt}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("t1_idle_armed", {31'd0, wb_cyc}, 32'd0);

    // Stale irq held through HOLD: only one reschedule.
    @(negedge clk);
    push_resched(32'd1050, 16'd2);
    rd_val = 32'd1000; period = 32'd50; irq = 1'b1;
    wait_tick("t2");
    repeat (2) @(posedge clk);
    @(negedge clk);
    irq = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t2_stale_idle", {31'd0, wb_cyc}, 32'd0);

    // Wrap-around write, then the immediate irq drives a second reschedule.
    @(negedge clk);
    push_resched(32'h0000_0010, 16'd3);
    push_resched(32'h0000_0031, 16'd4);
    rd_val = 32'hFFFF_FFF0; period = 32'h20; irq = 1'b1;
    wait_tick("t3a");
    rd_val = 32'h11;
    wait_tick("t3b");
    irq = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t3_idle", {31'd0, wb_cyc}, 32'd0);

    // Zero period behaves as one.
    @(negedge clk);
    push_resched(32'd501, 16'd5);
    rd_val = 32'd500; period = 32'd0; irq = 1'b1;
    wait_tick("t4");
    irq = 1'b0;
    repeat (6) @(posedge clk);

    // Reset in the middle of the write transaction.
    @(negedge clk);
    exp_xfer.push_back('{we: 1'b0, dat: 32'd0});
    rd_val = 32'd20; period = 32'd5; irq = 1'b1;
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge clk);
        if (wb_cyc && wb_we) found = 1'b1;
      end
      chk("t5_reached_wr", {31'd0, found}, 32'd1);
    end
    rst = 1'b1; irq = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_cyc_cleared", {31'd0, wb_cyc}, 32'd0);
    chk("t5_we_cleared", {31'd0, wb_we}, 32'd0);
    chk("t5_cnt_cleared", {16'd0, tick_cnt}, 32'd0);
    chk("t5_dat_cleared", wb_dat_o, 32'd0);
    @(negedge clk);
    push_resched(32'd35, 16'd1);
    rd_val = 32'd30; rst = 1'b0;
    wait_tick("t5_rearm");
    repeat (6) @(posedge clk);

    // Responder never acks.
    @(negedge clk);
    noack = 1'b1; irq = 1'b1;
    begin
      logic up;
      up = 1'b0;
      for (int i = 0; i < 20 && !up; i++) begin
        @(posedge clk);
        #1;
        if (wb_cyc) up = 1'b1;
      end
      chk("t6_cyc_up", {31'd0, up}, 32'd1);
    end
`ifdef SERVANT_TICK_TIMEOUT_EN
    repeat (14) @(posedge clk);
    #1;
    chk("t6_cyc_before_to", {31'd0, wb_cyc}, 32'd1);
    @(posedge clk);
    #1;
    chk("t6_cyc_dropped", {31'd0, wb_cyc}, 32'd0);
    chk("t6_err_set", {31'd0, err}, 32'd1);
`else
    repeat (20) @(posedge clk);
    #1;
    chk("t6_cyc_held", {31'd0, wb_cyc}, 32'd1);
    chk("t6_err_zero", {31'd0, err}, 32'd0);
`endif
    irq = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("xfer_queue_empty", exp_xfer.size(), 32'd0);
    chk("tick_queue_empty", exp_tick.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
